// File: rtl/leds_pkg.sv
// Shared defaults and sizing helper for the button-to-LED front end.
package leds_pkg;

  localparam int unsigned DEF_WIDTH           = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2;
  localparam int unsigned DEF_CNT_W           = 20;

  // Minimum counter width able to hold the value `cycles`.
  function automatic int unsigned cnt_bits(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: two-flop synchroniser followed by a stability counter.
module debounce_bit
  import leds_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_CYCLES < 1 || CNT_W < cnt_bits(DEBOUNCE_CYCLES)) begin : g_bad_param
    $fatal(1, "debounce_bit: DEBOUNCE_CYCLES=%0d illegal for CNT_W=%0d", DEBOUNCE_CYCLES, CNT_W);
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q, st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    if (s2_q != st_q) begin
      if (cnt_q == CntLast) begin
        st_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = st_q;

endmodule

// File: rtl/leds_ctrl.sv
// Button-to-LED front end: one debounced channel per button, optional LED inversion.
module leds_ctrl
  import leds_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter bit          INVERT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] but,
  output logic [WIDTH-1:0] led
);

  logic [WIDTH-1:0] st;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (but[i]),
      .dout (st[i])
    );
  end

  // Driven only from registers, so reset forces led to the INVERT level.
  assign led = st ^ {WIDTH{INVERT}};

endmodule

// File: tb/tb_leds_ctrl.sv
// Bench for leds_ctrl: default instance plus an inverted, slower instance vs a run-length model.
module tb_leds_ctrl;

  localparam int unsigned DC0 = 2;
  localparam int unsigned DC1 = 5;

  logic       clk, rst_n;
  logic [1:0] but0, but1, led0, led1;

  int n_asrt = 0;
  int n_fail = 0;

  leds_ctrl u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .but  (but0),
    .led  (led0)
  );

  leds_ctrl #(
    .DEBOUNCE_CYCLES(DC1),
    .INVERT         (1'b1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .but  (but1),
    .led  (led1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference: a channel's accepted level flips once the level seen two edges after
  // sampling has disagreed with it for DC consecutive edges.
  logic [1:0]  h0a, h1a, st0, h0b, h1b, st1;
  int unsigned run0 [2];
  int unsigned run1 [2];
  logic [1:0]  m0, m1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0a <= '0; h1a <= '0; st0 <= '0;
      h0b <= '0; h1b <= '0; st1 <= '0;
      for (int i = 0; i < 2; i++) begin
        run0[i] <= 0;
        run1[i] <= 0;
      end
    end else begin
      h0a <= but0; h1a <= h0a;
      h0b <= but1; h1b <= h0b;
      for (int i = 0; i < 2; i++) begin
        if (h1a[i] != st0[i]) begin
          if (run0[i] + 1 == DC0) begin st0[i] <= h1a[i]; run0[i] <= 0; end
          else run0[i] <= run0[i] + 1;
        end else run0[i] <= 0;
        if (h1b[i] != st1[i]) begin
          if (run1[i] + 1 == DC1) begin st1[i] <= h1b[i]; run1[i] <= 0; end
          else run1[i] <= run1[i] + 1;
        end else run1[i] <= 0;
      end
    end
  end

  assign m0 = st0;
  assign m1 = ~st1;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model0", led0, m0);
    chk("model1", led1, m1);
  endtask

  logic [1:0] prev;

  initial begin
    rst_n = 1'b0;
    but0  = 2'b11;
    but1  = 2'b00;

    // Reset holds LEDs at the inactive level
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("reset_led0", led0, 2'b00);
      chk("reset_led1", led1, 2'b11);
    end
    rst_n = 1'b1;
    but0  = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_reset", led0, 2'b00);
    end

    // Value sweep with exact 4-edge latency
    prev = 2'b00;
    for (int v = 0; v < 4; v++) begin
      but0 = 2'(v);
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (c < 4) chk("sweep_hold", led0, prev);
        else       chk("sweep_new", led0, 2'(v));
      end
      prev = 2'(v);
    end
    but0 = 2'b00;
    repeat (5) tick();

    // One-cycle glitch is rejected
    but0 = 2'b01;
    tick();
    but0 = 2'b00;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("glitch", led0, 2'b00);
    end
    // Two-cycle pulse is accepted
    but0 = 2'b01;
    tick();
    tick();
    but0 = 2'b00;
    tick();
    tick();
    chk("stable2", led0, 2'b01);
    repeat (6) tick();
    chk("stable2_fall", led0, 2'b00);

    // Async reset mid-debounce discards the pending change
    but0 = 2'b11;
    repeat (3) tick();
    #20 rst_n = 1'b0;
    #1;
    chk("async_led0", led0, 2'b00);
    chk("async_led1", led1, 2'b11);
    repeat (3) begin
      tick();
      chk("in_reset", led0, 2'b00);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk((c < 4) ? "release_hold" : "release_new", led0, (c < 4) ? 2'b00 : 2'b11);
    end
    // Async reset clears a settled output immediately
    #20 rst_n = 1'b0;
    #1;
    chk("async_clear", led0, 2'b00);
    but0 = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Inverted, slower instance: 7-edge latency
    but1 = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 6) chk("inv_hold", led1, 2'b11);
      if (c == 7) chk("inv_new", led1, 2'b10);
    end
    but1 = 2'b00;
    repeat (8) tick();

    // Simultaneous opposite transitions land on the same edge
    but0 = 2'b01;
    repeat (5) tick();
    but0 = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk((c < 4) ? "simul_hold" : "simul_new", led0, (c < 4) ? 2'b01 : 2'b10);
    end

    // Random levels with random hold times
    for (int r = 0; r < 80; r++) begin
      but0 = 2'($urandom);
      but1 = 2'($urandom);
      repeat ($urandom_range(1, 9)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
